// File: rtl/mem_bus_arbiter_if.sv
// Native valid/ready memory bus: one request/completion channel between a master and a slave.
// The master holds valid until ready pulses; rdata is meaningful only in the ready cycle.
interface mem_bus_arbiter_if;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter with timeout watchdog; 1 cycle arbitration, then combinational pass-through.
// Grant is held until s_ready or timeout; the losing master sees ready=0 and simply waits.
module mem_bus_arbiter #(
  parameter int          TIMEOUT  = 256,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF,
  parameter int          CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  mem_bus_arbiter_if.slave          m0,
  mem_bus_arbiter_if.slave          m1,
  mem_bus_arbiter_if.master         s,
  output logic [1:0]                grant,
  output logic                      bus_err,
  output logic                      err_master,
  output logic [31:0]               err_addr,
  input  logic                      err_clr
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic             last;
  logic [CNT_W-1:0] cnt;

  logic        owned;
  logic        sel;
  logic        cur_valid;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [3:0]  cur_wstrb;
  logic        timeout_hit;
  logic        done;

  assign owned     = (state != IDLE);
  assign sel       = (state == OWN1);
  assign cur_valid = sel ? m1.valid : m0.valid;
  assign cur_addr  = sel ? m1.addr  : m0.addr;
  assign cur_wdata = sel ? m1.wdata : m0.wdata;
  assign cur_wstrb = sel ? m1.wstrb : m0.wstrb;

  // Slave readiness takes priority over the watchdog in the same cycle.
  assign timeout_hit = (TIMEOUT != 0) && owned && cur_valid && !s.ready && (cnt == CNT_LAST);
  assign done        = owned && cur_valid && (s.ready || timeout_hit);

  assign grant = {state == OWN1, state == OWN0};

  always_comb begin
    s.valid  = 1'b0;
    s.addr   = '0;
    s.wdata  = '0;
    s.wstrb  = '0;
    m0.ready = 1'b0;
    m0.rdata = '0;
    m1.ready = 1'b0;
    m1.rdata = '0;
    if (owned) begin
      s.valid = cur_valid && !timeout_hit;
      s.addr  = cur_addr;
      s.wdata = cur_wdata;
      s.wstrb = cur_wstrb;
      if (sel) begin
        m1.ready = done;
        m1.rdata = timeout_hit ? ERR_DATA : s.rdata;
      end else begin
        m0.ready = done;
        m0.rdata = timeout_hit ? ERR_DATA : s.rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last       <= 1'b1;
      cnt        <= '0;
      bus_err    <= 1'b0;
      err_master <= 1'b0;
      err_addr   <= '0;
    end else begin
      if (err_clr) bus_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (m0.valid && m1.valid) state <= last ? OWN0 : OWN1;
          else if (m0.valid)        state <= OWN0;
          else if (m1.valid)        state <= OWN1;
        end
        default: begin
          if (!cur_valid) begin
            // Master withdrew its request: release without touching round-robin order.
            state <= IDLE;
            cnt   <= '0;
          end else if (done) begin
            state <= IDLE;
            last  <= sel;
            cnt   <= '0;
            if (timeout_hit) begin
              bus_err    <= 1'b1;
              err_master <= sel;
              err_addr   <= cur_addr;
            end
          end else if (TIMEOUT != 0) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: inputs change at negedge, outputs checked 1 time unit later.
module tb_mem_bus_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  grant;
  logic        bus_err;
  logic        err_master;
  logic [31:0] err_addr;
  logic        err_clr = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  mem_bus_arbiter_if m0_bus ();
  mem_bus_arbiter_if m1_bus ();
  mem_bus_arbiter_if s_bus ();

  mem_bus_arbiter #(.TIMEOUT(8), .ERR_DATA(32'hDEAD_BEEF), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .m0         (m0_bus),
    .m1         (m1_bus),
    .s          (s_bus),
    .grant      (grant),
    .bus_err    (bus_err),
    .err_master (err_master),
    .err_addr   (err_addr),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    m0_bus.valid = 0; m0_bus.addr = 0; m0_bus.wdata = 0; m0_bus.wstrb = 0;
    m1_bus.valid = 0; m1_bus.addr = 0; m1_bus.wdata = 0; m1_bus.wstrb = 0;
    s_bus.ready = 0; s_bus.rdata = 0;

    // Reset state
    step(); #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_svalid", 32'(s_bus.valid), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_err_master", 32'(err_master), 32'd0);
    chk("rst_err_addr", err_addr, 32'd0);
    reset = 0;

    // Single m0 read, slave ready on second owned cycle
    step(); m0_bus.valid = 1; m0_bus.addr = 32'h0002_0010; #1;
    chk("t1_arb_grant", 32'(grant), 32'd0);
    chk("t1_arb_svalid", 32'(s_bus.valid), 32'd0);
    step(); #1;
    chk("t1_grant", 32'(grant), 32'b01);
    chk("t1_svalid", 32'(s_bus.valid), 32'd1);
    chk("t1_saddr", s_bus.addr, 32'h0002_0010);
    chk("t1_wait_ready", 32'(m0_bus.ready), 32'd0);
    step(); s_bus.ready = 1; s_bus.rdata = 32'h1234_5678; #1;
    chk("t1_ready", 32'(m0_bus.ready), 32'd1);
    chk("t1_rdata", m0_bus.rdata, 32'h1234_5678);
    step(); m0_bus.valid = 0; s_bus.ready = 0; #1;
    chk("t1_idle_grant", 32'(grant), 32'd0);
    chk("t1_idle_ready", 32'(m0_bus.ready), 32'd0);

    // Re-reset so round-robin pointer favours m0, then contention
    step(); reset = 1; #1;
    step(); reset = 0;
    step(); m0_bus.valid = 1; m0_bus.addr = 32'h100; m1_bus.valid = 1; m1_bus.addr = 32'h200; #1;
    chk("t2_arb_grant", 32'(grant), 32'd0);
    step(); s_bus.ready = 1; s_bus.rdata = 32'hAAAA_0000; #1;
    chk("t2_g0", 32'(grant), 32'b01);
    chk("t2_saddr0", s_bus.addr, 32'h100);
    chk("t2_m0_ready", 32'(m0_bus.ready), 32'd1);
    chk("t2_m1_ready_blocked", 32'(m1_bus.ready), 32'd0);
    chk("t2_m1_rdata_blocked", m1_bus.rdata, 32'd0);
    step(); m0_bus.valid = 0; s_bus.ready = 0; #1;
    chk("t2_idle", 32'(grant), 32'd0);
    chk("t2_m1_idle_ready", 32'(m1_bus.ready), 32'd0);
    step(); s_bus.ready = 1; s_bus.rdata = 32'hBBBB_0001; #1;
    chk("t2_g1", 32'(grant), 32'b10);
    chk("t2_saddr1", s_bus.addr, 32'h200);
    chk("t2_m1_ready", 32'(m1_bus.ready), 32'd1);
    chk("t2_m1_rdata", m1_bus.rdata, 32'hBBBB_0001);
    chk("t2_m0_ready_other", 32'(m0_bus.ready), 32'd0);
    step(); m1_bus.valid = 0; s_bus.ready = 0;

    // Both masters hold valid, slave always ready: strict alternation with IDLE gaps
    step(); m0_bus.valid = 1; m1_bus.valid = 1; s_bus.ready = 1; #1;
    chk("t3_start_idle", 32'(grant), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step(); #1;
      chk($sformatf("t3_grant%0d", i), 32'(grant), (i % 2 == 0) ? 32'b01 : 32'b10);
      chk($sformatf("t3_m0_ready%0d", i), 32'(m0_bus.ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      step();
      if (i == 5) begin m0_bus.valid = 0; m1_bus.valid = 0; s_bus.ready = 0; end
      #1;
      chk($sformatf("t3_gap%0d", i), 32'(grant), 32'd0);
    end

    // m1 write to unmapped address, slave never ready, TIMEOUT=8
    step(); m1_bus.valid = 1; m1_bus.addr = 32'h4000_0000; m1_bus.wdata = 32'h55; m1_bus.wstrb = 4'hF; #1;
    for (int k = 1; k < 8; k++) begin
      step(); #1;
      chk($sformatf("t4_wait%0d", k), {29'd0, grant, m1_bus.ready}, {29'd0, 2'b10, 1'b0});
    end
    step(); #1;
    chk("t4_to_ready", 32'(m1_bus.ready), 32'd1);
    chk("t4_to_rdata", m1_bus.rdata, 32'hDEAD_BEEF);
    chk("t4_to_svalid", 32'(s_bus.valid), 32'd0);
    chk("t4_err_not_yet", 32'(bus_err), 32'd0);
    step(); m1_bus.valid = 0; err_clr = 1; #1;
    chk("t4_bus_err", 32'(bus_err), 32'd1);
    chk("t4_err_master", 32'(err_master), 32'd1);
    chk("t4_err_addr", err_addr, 32'h4000_0000);
    chk("t4_idle", 32'(grant), 32'd0);
    step(); err_clr = 0; #1;
    chk("t4_cleared", 32'(bus_err), 32'd0);
    chk("t4_addr_kept", err_addr, 32'h4000_0000);

    // m0 completes (pointer -> m0), holds valid, then reset hits mid-grant
    step(); m0_bus.valid = 1; m0_bus.addr = 32'h300; m0_bus.wstrb = 4'h0; #1;
    step(); s_bus.ready = 1; #1;
    chk("t5_first_done", 32'(m0_bus.ready), 32'd1);
    step(); s_bus.ready = 0; #1;
    chk("t5_b2b_gap", 32'(grant), 32'd0);
    step(); #1;
    chk("t5_regrant", 32'(grant), 32'b01);
    step(); reset = 1; #1;
    chk("t5_rst_grant", 32'(grant), 32'd0);
    chk("t5_rst_svalid", 32'(s_bus.valid), 32'd0);
    chk("t5_rst_ready", 32'(m0_bus.ready), 32'd0);
    step(); reset = 0; m1_bus.valid = 1; m1_bus.addr = 32'h400; #1;
    step(); #1;
    chk("t5_m0_wins", 32'(grant), 32'b01);

    // m0 aborts mid-grant with slave ready present: no completion, m1 next
    step(); m0_bus.valid = 0; s_bus.ready = 1; #1;
    chk("t6_abort_ready", 32'(m0_bus.ready), 32'd0);
    chk("t6_abort_svalid", 32'(s_bus.valid), 32'd0);
    step(); s_bus.ready = 0; #1;
    chk("t6_idle", 32'(grant), 32'd0);
    step(); #1;
    chk("t6_m1_grant", 32'(grant), 32'b10);
    chk("t6_m1_addr", s_bus.addr, 32'h400);
    step(); s_bus.ready = 1; s_bus.rdata = 32'h0BAD_F00D; #1;
    chk("t6_m1_ready", 32'(m1_bus.ready), 32'd1);
    chk("t6_m1_rdata", m1_bus.rdata, 32'h0BAD_F00D);
    step(); m1_bus.valid = 0; s_bus.ready = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
